// File: rtl/cva6_cfg_dump.sv
// Packs the elaborated CVA6 configuration into a fixed 32-bit word map, served as a
// valid/ready dump stream and a 1-cycle random read port. Checksum word w8: CVA6_CFG_DUMP_CSUM_EN.
package config_pkg;
  typedef struct packed {
    logic [31:0] XLEN;
    logic        RVA;
    logic        RVB;
    logic        RVC;
    logic        RVF;
    logic        RVD;
    logic        RVH;
    logic        RVV;
    logic        RVS;
    logic        RVU;
    logic        RVZCB;
    logic        RVZCMP;
    logic        RVZiCond;
    logic        CvxifEn;
    logic        MmuPresent;
    logic        DebugEn;
    logic        PerfCounterEn;
    logic [31:0] IcacheByteSize;
    logic [31:0] IcacheSetAssoc;
    logic [31:0] IcacheLineWidth;
    logic [31:0] DcacheByteSize;
    logic [31:0] DcacheSetAssoc;
    logic [31:0] DcacheLineWidth;
    logic [31:0] NrScoreboardEntries;
    logic [31:0] NrPMPEntries;
    logic [31:0] RASDepth;
    logic [31:0] NrCommitPorts;
    logic [31:0] BTBEntries;
    logic [31:0] BHTEntries;
    logic [31:0] MaxOutstandingStores;
    logic [31:0] WtDcacheWbufDepth;
  } cva6_cfg_t;

  localparam cva6_cfg_t cva6_cfg_empty = '0;
endpackage

module cva6_cfg_dump #(
  parameter config_pkg::cva6_cfg_t CVA6Cfg = config_pkg::cva6_cfg_empty,
  localparam int unsigned NrPayloadWords = 8
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic        abort_i,
  output logic [31:0] data_o,
  output logic [3:0]  idx_o,
  output logic        last_o,
  output logic        valid_o,
  input  logic        ready_i,
  output logic        busy_o,
  output logic        done_o,
  input  logic        rd_req_i,
  input  logic [3:0]  rd_addr_i,
  output logic        rd_valid_o,
  output logic [31:0] rd_data_o,
  output logic        rd_err_o
);

  localparam logic [31:0] IcLineBytes = CVA6Cfg.IcacheLineWidth >> 3;
  localparam logic [31:0] DcLineBytes = CVA6Cfg.DcacheLineWidth >> 3;

  localparam logic [31:0] Word0 = 32'hC0A6_0001;
  localparam logic [31:0] Word1 = {8'h00, CVA6Cfg.XLEN[7:0],
    CVA6Cfg.PerfCounterEn, CVA6Cfg.DebugEn, CVA6Cfg.MmuPresent, CVA6Cfg.CvxifEn,
    CVA6Cfg.RVZiCond, CVA6Cfg.RVZCMP, CVA6Cfg.RVZCB, CVA6Cfg.RVU,
    CVA6Cfg.RVS, CVA6Cfg.RVV, CVA6Cfg.RVH, CVA6Cfg.RVD,
    CVA6Cfg.RVF, CVA6Cfg.RVC, CVA6Cfg.RVB, CVA6Cfg.RVA};
  localparam logic [31:0] Word2 = CVA6Cfg.IcacheByteSize;
  localparam logic [31:0] Word3 = CVA6Cfg.DcacheByteSize;
  localparam logic [31:0] Word4 = {DcLineBytes[7:0], IcLineBytes[7:0],
    CVA6Cfg.DcacheSetAssoc[7:0], CVA6Cfg.IcacheSetAssoc[7:0]};
  localparam logic [31:0] Word5 = {CVA6Cfg.NrCommitPorts[7:0], CVA6Cfg.RASDepth[7:0],
    CVA6Cfg.NrPMPEntries[7:0], CVA6Cfg.NrScoreboardEntries[7:0]};
  localparam logic [31:0] Word6 = {CVA6Cfg.BHTEntries[15:0], CVA6Cfg.BTBEntries[15:0]};
  localparam logic [31:0] Word7 = {CVA6Cfg.WtDcacheWbufDepth[15:0],
    CVA6Cfg.MaxOutstandingStores[15:0]};

`ifdef CVA6_CFG_DUMP_CSUM_EN
  localparam logic [31:0] Word8 = Word0 ^ Word1 ^ Word2 ^ Word3 ^ Word4 ^ Word5 ^ Word6 ^ Word7;
  localparam int unsigned NrWords = NrPayloadWords + 1;
`else
  localparam int unsigned NrWords = NrPayloadWords;
`endif

  localparam logic [3:0] LastIdx = 4'(NrWords - 1);

  // Out-of-map indices decode to zero, which doubles as the read-error data value.
  function automatic logic [31:0] word_at(input logic [3:0] idx);
    case (idx)
      4'd0:    return Word0;
      4'd1:    return Word1;
      4'd2:    return Word2;
      4'd3:    return Word3;
      4'd4:    return Word4;
      4'd5:    return Word5;
      4'd6:    return Word6;
      4'd7:    return Word7;
`ifdef CVA6_CFG_DUMP_CSUM_EN
      4'd8:    return Word8;
`endif
      default: return '0;
    endcase
  endfunction

  typedef enum logic {Idle, Send} state_e;

  state_e      state_q;
  logic [31:0] data_q;
  logic [3:0]  idx_q;
  logic [3:0]  idx_d;
  logic        last_q;
  logic        valid_q;
  logic        busy_q;
  logic        done_q;
  logic        rd_valid_q;
  logic [31:0] rd_data_q;
  logic        rd_err_q;

  assign idx_d = idx_q + 4'd1;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= Idle;
      data_q  <= '0;
      idx_q   <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (abort_i) begin
        state_q <= Idle;
        data_q  <= '0;
        idx_q   <= '0;
        last_q  <= 1'b0;
        valid_q <= 1'b0;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          Idle: begin
            if (start_i) begin
              state_q <= Send;
              data_q  <= Word0;
              idx_q   <= '0;
              last_q  <= 1'b0;
              valid_q <= 1'b1;
              busy_q  <= 1'b1;
            end
          end
          Send: begin
            if (valid_q && ready_i) begin
              if (last_q) begin
                state_q <= Idle;
                data_q  <= '0;
                idx_q   <= '0;
                last_q  <= 1'b0;
                valid_q <= 1'b0;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end else begin
                data_q <= word_at(idx_d);
                idx_q  <= idx_d;
                last_q <= (idx_d == LastIdx);
              end
            end
          end
          default: state_q <= Idle;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_err_q   <= 1'b0;
    end else begin
      rd_valid_q <= rd_req_i;
      rd_data_q  <= rd_req_i ? word_at(rd_addr_i) : '0;
      rd_err_q   <= rd_req_i && (rd_addr_i > LastIdx);
    end
  end

  assign data_o     = data_q;
  assign idx_o      = idx_q;
  assign last_o     = last_q;
  assign valid_o    = valid_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign rd_valid_o = rd_valid_q;
  assign rd_data_o  = rd_data_q;
  assign rd_err_o   = rd_err_q;

endmodule

// File: tb/tb_cva6_cfg_dump.sv
// Scoreboard bench for cva6_cfg_dump using the cv32a6_imac_sv0 configuration.
module tb_cva6_cfg_dump;

  localparam config_pkg::cva6_cfg_t ImacSv0 = '{
    XLEN: 32'd32, RVA: 1'b1, RVB: 1'b0, RVC: 1'b1, RVF: 1'b0, RVD: 1'b0, RVH: 1'b0,
    RVV: 1'b0, RVS: 1'b1, RVU: 1'b1, RVZCB: 1'b0, RVZCMP: 1'b0, RVZiCond: 1'b0,
    CvxifEn: 1'b0, MmuPresent: 1'b1, DebugEn: 1'b1, PerfCounterEn: 1'b1,
    IcacheByteSize: 32'd16384, IcacheSetAssoc: 32'd4, IcacheLineWidth: 32'd128,
    DcacheByteSize: 32'd32768, DcacheSetAssoc: 32'd8, DcacheLineWidth: 32'd128,
    NrScoreboardEntries: 32'd8, NrPMPEntries: 32'd8, RASDepth: 32'd2, NrCommitPorts: 32'd2,
    BTBEntries: 32'd32, BHTEntries: 32'd128, MaxOutstandingStores: 32'd7,
    WtDcacheWbufDepth: 32'd8};

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        start_i = 1'b0;
  logic        abort_i = 1'b0;
  logic [31:0] data_o;
  logic [3:0]  idx_o;
  logic        last_o;
  logic        valid_o;
  logic        ready_i = 1'b0;
  logic        busy_o;
  logic        done_o;
  logic        rd_req_i = 1'b0;
  logic [3:0]  rd_addr_i = '0;
  logic        rd_valid_o;
  logic [31:0] rd_data_o;
  logic        rd_err_o;

  cva6_cfg_dump #(.CVA6Cfg(ImacSv0)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .abort_i(abort_i),
    .data_o(data_o), .idx_o(idx_o), .last_o(last_o), .valid_o(valid_o),
    .ready_i(ready_i), .busy_o(busy_o), .done_o(done_o),
    .rd_req_i(rd_req_i), .rd_addr_i(rd_addr_i), .rd_valid_o(rd_valid_o),
    .rd_data_o(rd_data_o), .rd_err_o(rd_err_o)
  );

  always #5 clk_i = ~clk_i;

  logic [73:0] all_out;
  assign all_out = {data_o, idx_o, last_o, valid_o, busy_o, done_o, rd_valid_o, rd_data_o, rd_err_o};

  int          pass_cnt = 0;
  int          total_cnt = 0;
  int          nw;
  logic [31:0] exp_w [9];
  int          sb_q [$];
  logic [32:0] rd_q [$];

  task automatic test_reset();
    @(negedge clk_i);
    total_cnt++;
    if (all_out !== '0) $display("FAIL reset_outputs: got %h want 0", all_out);
    else pass_cnt++;
    rst_ni = 1'b1;
    @(negedge clk_i);
    total_cnt++;
    if (all_out !== '0) $display("FAIL post_reset_idle: got %h want 0", all_out);
    else pass_cnt++;
  endtask

  task automatic test_full_dump();
    int hs = 0, dones = 0, last_hs = -1, done_c = -1, n;
    sb_q.delete();
    ready_i = 1'b1; start_i = 1'b1;
    for (int i = 0; i < nw; i++) sb_q.push_back(i);
    @(negedge clk_i);
    start_i = 1'b0;
    total_cnt++;
    if ({valid_o, busy_o, idx_o} !== {2'b11, 4'd0})
      $display("FAIL start_latency: got v=%b b=%b idx=%0d want v=1 b=1 idx=0", valid_o, busy_o, idx_o);
    else pass_cnt++;
    for (int c = 0; c < 20; c++) begin
      if (done_o) begin dones++; done_c = c; end
      if (valid_o && ready_i) begin
        n = (sb_q.size() > 0) ? sb_q.pop_front() : 15;
        total_cnt++;
        if (n > 8 || {data_o, idx_o, last_o} !== {exp_w[n], 4'(n), n == nw - 1})
          $display("FAIL dump_word: got d=%h idx=%0d last=%b want idx=%0d", data_o, idx_o, last_o, n);
        else pass_cnt++;
        hs++; last_hs = c;
      end
      @(negedge clk_i);
    end
    total_cnt++;
    if (hs != nw || last_hs != nw - 1 || sb_q.size() != 0)
      $display("FAIL dump_count: got hs=%0d last_cycle=%0d want hs=%0d last_cycle=%0d", hs, last_hs, nw, nw - 1);
    else pass_cnt++;
    total_cnt++;
    if (dones != 1 || done_c != nw)
      $display("FAIL dump_done: got pulses=%0d at %0d want 1 at %0d", dones, done_c, nw);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    int hs = 0, dones = 0, stall = 0, n;
    sb_q.delete();
    ready_i = 1'b1; start_i = 1'b1;
    for (int i = 0; i < nw; i++) sb_q.push_back(i);
    @(negedge clk_i);
    start_i = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (done_o) dones++;
      if (valid_o && idx_o == 4'd3 && stall < 3) begin
        ready_i = 1'b0;
        stall++;
        total_cnt++;
        if ({data_o, idx_o} !== {32'h0000_8000, 4'd3})
          $display("FAIL stall_hold: got d=%h idx=%0d want d=00008000 idx=3", data_o, idx_o);
        else pass_cnt++;
      end else ready_i = 1'b1;
      if (valid_o && ready_i) begin
        n = (sb_q.size() > 0) ? sb_q.pop_front() : 15;
        total_cnt++;
        if (n > 8 || {data_o, idx_o, last_o} !== {exp_w[n], 4'(n), n == nw - 1})
          $display("FAIL stall_word: got d=%h idx=%0d last=%b want idx=%0d", data_o, idx_o, last_o, n);
        else pass_cnt++;
        hs++;
      end
      @(negedge clk_i);
    end
    ready_i = 1'b1;
    total_cnt++;
    if (hs != nw || dones != 1 || stall != 3 || sb_q.size() != 0)
      $display("FAIL stall_count: got hs=%0d done=%0d stalls=%0d want hs=%0d done=1 stalls=3", hs, dones, stall, nw);
    else pass_cnt++;
  endtask

  task automatic test_abort();
    int hs = 0, dones = 0, seen = 0, n;
    sb_q.delete();
    ready_i = 1'b1; start_i = 1'b1;
    for (int i = 0; i < 4; i++) sb_q.push_back(i);
    @(negedge clk_i);
    start_i = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (valid_o && idx_o == 4'd4) begin abort_i = 1'b1; seen = 1; break; end
      if (valid_o && ready_i) begin
        n = (sb_q.size() > 0) ? sb_q.pop_front() : 15;
        total_cnt++;
        if (n > 8 || {data_o, idx_o} !== {exp_w[n], 4'(n)})
          $display("FAIL abort_pre_word: got d=%h idx=%0d want idx=%0d", data_o, idx_o, n);
        else pass_cnt++;
      end
      @(negedge clk_i);
    end
    @(negedge clk_i);
    abort_i = 1'b0;
    total_cnt++;
    if (seen != 1 || {valid_o, busy_o} !== 2'b00)
      $display("FAIL abort_stop: got seen=%0d v=%b b=%b want seen=1 v=0 b=0", seen, valid_o, busy_o);
    else pass_cnt++;
    for (int c = 0; c < 4; c++) begin
      if (done_o || valid_o) dones++;
      @(negedge clk_i);
    end
    total_cnt++;
    if (dones != 0) $display("FAIL abort_no_done: got %0d stray cycles want 0", dones);
    else pass_cnt++;
    sb_q.delete();
    dones = 0;
    start_i = 1'b1;
    for (int i = 0; i < nw; i++) sb_q.push_back(i);
    @(negedge clk_i);
    start_i = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (done_o) dones++;
      if (valid_o && ready_i) begin
        n = (sb_q.size() > 0) ? sb_q.pop_front() : 15;
        total_cnt++;
        if (n > 8 || {data_o, idx_o, last_o} !== {exp_w[n], 4'(n), n == nw - 1})
          $display("FAIL restart_word: got d=%h idx=%0d last=%b want idx=%0d", data_o, idx_o, last_o, n);
        else pass_cnt++;
        hs++;
      end
      @(negedge clk_i);
    end
    total_cnt++;
    if (hs != nw || dones != 1) $display("FAIL restart_count: got hs=%0d done=%0d want hs=%0d done=1", hs, dones, nw);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int hs = 0, dones = 0, last_hs = -1, n;
    bit mid_start = 1'b0;
    sb_q.delete();
    ready_i = 1'b1; start_i = 1'b1;
    for (int i = 0; i < nw; i++) sb_q.push_back(i);
    @(negedge clk_i);
    start_i = 1'b0;
    for (int c = 0; c < 40; c++) begin
      start_i = 1'b0;
      if (valid_o && idx_o == 4'd2 && !mid_start) begin start_i = 1'b1; mid_start = 1'b1; end
      if (done_o) begin
        dones++;
        if (dones == 1) begin
          start_i = 1'b1;
          for (int i = 0; i < nw; i++) sb_q.push_back(i);
        end
      end
      if (valid_o && ready_i) begin
        n = (sb_q.size() > 0) ? sb_q.pop_front() : 15;
        total_cnt++;
        if (n > 8 || {data_o, idx_o, last_o} !== {exp_w[n], 4'(n), n == nw - 1})
          $display("FAIL b2b_word: got d=%h idx=%0d last=%b want idx=%0d", data_o, idx_o, last_o, n);
        else pass_cnt++;
        hs++; last_hs = c;
      end
      @(negedge clk_i);
    end
    start_i = 1'b0;
    total_cnt++;
    if (hs != 2 * nw || last_hs != 2 * nw || dones != 2 || sb_q.size() != 0)
      $display("FAIL b2b_count: got hs=%0d last=%0d done=%0d want hs=%0d last=%0d done=2",
               hs, last_hs, dones, 2 * nw, 2 * nw);
    else pass_cnt++;
    start_i = 1'b1; abort_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0; abort_i = 1'b0;
    total_cnt++;
    if ({valid_o, busy_o, idx_o} !== 6'b0) $display("FAIL start_abort_idle: got v=%b b=%b idx=%0d want 0", valid_o, busy_o, idx_o);
    else pass_cnt++;
    @(negedge clk_i);
    total_cnt++;
    if ({valid_o, busy_o, done_o} !== 3'b0) $display("FAIL start_abort_stay: got v=%b b=%b d=%b want 0", valid_o, busy_o, done_o);
    else pass_cnt++;
  endtask

  task automatic test_random_read();
    int hs = 0, resp = 0, first_c = -1, n;
    logic [32:0] e;
    logic [3:0] addrs [3];
    addrs[0] = 4'd0; addrs[1] = 4'd1; addrs[2] = 4'd15;
    sb_q.delete(); rd_q.delete();
    ready_i = 1'b1; start_i = 1'b1;
    for (int i = 0; i < nw; i++) sb_q.push_back(i);
    @(negedge clk_i);
    start_i = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (rd_valid_o) begin
        e = (rd_q.size() > 0) ? rd_q.pop_front() : 33'h1_DEAD_BEEF;
        total_cnt++;
        if ({rd_err_o, rd_data_o} !== e) $display("FAIL rd_resp: got err=%b d=%h want %h", rd_err_o, rd_data_o, e);
        else pass_cnt++;
        resp++;
        if (first_c < 0) first_c = c;
      end
      if (c < 3) begin
        rd_req_i = 1'b1; rd_addr_i = addrs[c];
        rd_q.push_back(c == 0 ? {1'b0, 32'hC0A6_0001} : c == 1 ? {1'b0, 32'h0020_E185} : {1'b1, 32'h0});
      end else rd_req_i = 1'b0;
      if (valid_o && ready_i) begin
        n = (sb_q.size() > 0) ? sb_q.pop_front() : 15;
        total_cnt++;
        if (n > 8 || {data_o, idx_o, last_o} !== {exp_w[n], 4'(n), n == nw - 1})
          $display("FAIL rd_stream_word: got d=%h idx=%0d want idx=%0d", data_o, idx_o, n);
        else pass_cnt++;
        hs++;
      end
      @(negedge clk_i);
    end
    total_cnt++;
    if (resp != 3 || first_c != 1 || hs != nw)
      $display("FAIL rd_count: got resp=%0d first=%0d hs=%0d want resp=3 first=1 hs=%0d", resp, first_c, hs, nw);
    else pass_cnt++;
  endtask

  task automatic test_async_reset();
    int hs = 0, dones = 0, stray = 0, n;
    sb_q.delete();
    ready_i = 1'b1; start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    for (int c = 0; c < 4; c++) @(negedge clk_i);
    rd_req_i = 1'b1; rd_addr_i = 4'd1;
    @(negedge clk_i);
    rd_req_i = 1'b0;
    #2 rst_ni = 1'b0;
    #1;
    total_cnt++;
    if (all_out !== '0) $display("FAIL async_clear: got %h want 0", all_out);
    else pass_cnt++;
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (done_o || valid_o || busy_o) stray++;
      @(negedge clk_i);
    end
    total_cnt++;
    if (stray != 0) $display("FAIL reset_no_done: got %0d active cycles want 0", stray);
    else pass_cnt++;
    start_i = 1'b1;
    for (int i = 0; i < nw; i++) sb_q.push_back(i);
    @(negedge clk_i);
    start_i = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (done_o) dones++;
      if (valid_o && ready_i) begin
        n = (sb_q.size() > 0) ? sb_q.pop_front() : 15;
        total_cnt++;
        if (n > 8 || {data_o, idx_o, last_o} !== {exp_w[n], 4'(n), n == nw - 1})
          $display("FAIL rst_redump_word: got d=%h idx=%0d want idx=%0d", data_o, idx_o, n);
        else pass_cnt++;
        hs++;
      end
      @(negedge clk_i);
    end
    total_cnt++;
    if (hs != nw || dones != 1) $display("FAIL rst_redump_count: got hs=%0d done=%0d want hs=%0d done=1", hs, dones, nw);
    else pass_cnt++;
  endtask

  initial begin
    exp_w[0] = 32'hC0A6_0001; exp_w[1] = 32'h0020_E185; exp_w[2] = 32'h0000_4000;
    exp_w[3] = 32'h0000_8000; exp_w[4] = 32'h1010_0804; exp_w[5] = 32'h0202_0808;
    exp_w[6] = 32'h0080_0020; exp_w[7] = 32'h0008_0007;
    exp_w[8] = exp_w[0] ^ exp_w[1] ^ exp_w[2] ^ exp_w[3] ^ exp_w[4] ^ exp_w[5] ^ exp_w[6] ^ exp_w[7];
`ifdef CVA6_CFG_DUMP_CSUM_EN
    nw = 9;
`else
    nw = 8;
`endif
    test_reset();
    test_full_dump();
    test_backpressure();
    test_abort();
    test_back_to_back();
    test_random_read();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/cva6_cfg_dump.md
# cva6_cfg_dump

Read-side counterpart of the CVA6 configuration package. It packs the elaborated `CVA6Cfg` structure into a fixed map of 32-bit words and offers it to software and debug in two ways. The first is a valid/ready stream that emits the whole map on request. The second is a random-access read port with single-cycle latency. The block sits beside the CSR file and debug module, and is how firmware and the bench discover the core's compiled-in configuration.

## Interface
Parameters:
- `CVA6Cfg`, default `config_pkg::cva6_cfg_empty`: elaborated core configuration; the only source of word contents.
- `NrPayloadWords`, default 8: number of config words (fixed map below); not user-overridable.

Ports:
- `clk_i` in 1: core clock.
- `rst_ni` in 1: asynchronous active-low reset.
- `start_i` in 1: request a full stream dump; sampled in IDLE only.
- `abort_i` in 1: terminate an active dump.
- `data_o` out 32: stream word.
- `idx_o` out 4: word index of `data_o`.
- `last_o` out 1: final word of the dump.
- `valid_o` out 1: stream word valid.
- `ready_i` in 1: stream consumer ready.
- `busy_o` out 1: dump in progress.
- `done_o` out 1: one-cycle pulse after the last handshake.
- `rd_req_i` in 1: random read strobe.
- `rd_addr_i` in 4: random read word index.
- `rd_valid_o` out 1: read response valid.
- `rd_data_o` out 32: read response data.
- `rd_err_o` out 1: read address out of range.

## Operation
Word map (all fields zero-extended, unused bits 0):
- w0: magic/version `32'hC0A6_0001`.
- w1: one flag per bit. [0] RVA, [1] RVB, [2] RVC, [3] RVF, [4] RVD, [5] RVH, [6] RVV, [7] RVS, [8] RVU, [9] RVZCB, [10] RVZCMP, [11] RVZiCond, [12] CvxifEn, [13] MmuPresent, [14] DebugEn, [15] PerfCounterEn. [23:16] XLEN.
- w2: IcacheByteSize. w3: DcacheByteSize.
- w4: [7:0] IcacheSetAssoc, [15:8] DcacheSetAssoc, [23:16] IcacheLineWidth/8, [31:24] DcacheLineWidth/8.
- w5: [7:0] NrScoreboardEntries, [15:8] NrPMPEntries, [23:16] RASDepth, [31:24] NrCommitPorts.
- w6: [15:0] BTBEntries, [31:16] BHTEntries.
- w7: [15:0] MaxOutstandingStores, [31:16] WtDcacheWbufDepth.
- w8 (checksum, see Configuration): XOR of w0..w7.
- Each field is truncated to its slot width.
- All words are elaboration constants; no storage is written at runtime.

Stream FSM:
- IDLE -> SEND when `start_i` is high. SEND -> IDLE after the handshake (`valid_o & ready_i`) with `last_o` high. Any state -> IDLE on `abort_i`.
- In SEND, the word counter advances by one per handshake. `data_o`, `idx_o` and `last_o` are registered and stay stable while `valid_o & !ready_i`.
- `last_o` is high only on the final word: w8 when the checksum is compiled in, w7 when it is not.
- `busy_o` is high in SEND.
- `done_o` pulses for one cycle after a completed dump. It does not pulse on abort.

Random read:
- A response is returned on every cycle where `rd_req_i` is high, independent of FSM state.
- The read port does not stall the stream, and the stream does not stall the read port.
- An address beyond the last valid word returns `rd_err_o=1`, `rd_data_o=0`.

## Timing
- Reset value of every output is 0. The FSM resets to IDLE and the counter to 0.
- `start_i` high in cycle N gives `valid_o=1`, `idx_o=0` in cycle N+1.
- With `ready_i` held high, one word is transferred per cycle. A full dump takes 9 cycles, or 8 without the checksum.
- `done_o` is high in the cycle after the last handshake. `start_i` in the `done_o` cycle is accepted.
- `start_i` while busy is ignored; there is no queuing.
- `abort_i` high in cycle N gives `valid_o=0` and `busy_o=0` in N+1. If abort and start are high together, abort wins and the block stays idle.
- `rd_req_i` in cycle N gives `rd_valid_o`, `rd_data_o` and `rd_err_o` in N+1. Back-to-back requests get back-to-back responses.
- Asynchronous reset mid-dump clears all outputs immediately. No `done_o` pulse follows.

## Configuration
- `CVA6_CFG_DUMP_CSUM_EN` defined: w8 checksum exists, stream length is 9, and rd addresses 0..8 are valid.
- Not defined: no checksum logic, stream length is 8, `last_o` is on w7, and address 8 is an error.

## Test plan
- Dump with `ready_i`=1 and the cv32a6_imac_sv0 config: w1=`32'h0020E185`, w2=`32'h4000`, w3=`32'h8000`, w4=`32'h10100804`, w5=`32'h02020808`, w6=`32'h00800020`, w7=`32'h00080007`. `last_o` is on idx 8 (or 7), and `done_o` pulses once.
- `ready_i` low for 3 cycles on idx 3: `data_o=32'h8000` and `idx_o=3` hold stable, and there are no skipped or duplicated words.
- `abort_i` at idx 4: `valid_o` and `busy_o` are 0 the next cycle and there is no `done_o`. A following `start_i` restarts at idx 0.
- `start_i` while busy and a simultaneous start+abort in IDLE: both are ignored and the stream contents are unchanged.
- Random reads of addrs 0, 1, 15 back-to-back during a dump: responses are `32'hC0A6_0001`, `32'h0020E185`, then 0 with `rd_err_o=1`. The stream is unaffected.
- Assert `rst_ni` low mid-dump: all outputs are 0 immediately. After release, IDLE, and a full dump is repeatable.
